// File: rtl/assert_log_pkg.sv
// Shared types for the assertion failure logger: status encoding and log entry layout.
package assert_log_pkg;

  localparam int NUM_CHECKERS_DEF = 4;
  localparam int TS_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_FAILED     = 2'd1,
    ST_OVERFLOWED = 2'd2
  } status_t;

  typedef struct packed {
    logic [NUM_CHECKERS_DEF-1:0] mask;
    logic [TS_WIDTH_DEF-1:0]     ts;
  } log_entry_t;

endpackage

// File: rtl/log_fifo.sv
// Show-ahead FIFO for failure log entries; pointers carry an extra wrap bit to tell full from empty.
module log_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/assertion_fail_logger.sv
// Timestamps cycles with any failing checker, logs them in a FIFO and tracks counts and sticky status.
//   state         | meaning
//   ST_OK         | no failure seen since reset/clear
//   ST_FAILED     | at least one failure logged
//   ST_OVERFLOWED | a failure entry was lost to a full FIFO (sticky until clear)
module assertion_fail_logger
  import assert_log_pkg::*;
#(
  parameter int NUM_CHECKERS = 4,
  parameter int TS_WIDTH     = 16,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHECKERS-1:0] fail_i,
  input  logic                    clear,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [NUM_CHECKERS-1:0] rd_mask,
  output logic [TS_WIDTH-1:0]     rd_ts,
  output logic [CNT_WIDTH-1:0]    fail_count,
  output logic [NUM_CHECKERS-1:0] first_mask,
  output logic [1:0]              status,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam int EW = NUM_CHECKERS + TS_WIDTH;

  status_t             state_q;
  status_t             state_d;
  logic [TS_WIDTH-1:0] ts;
  logic                any_fail;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push;
  logic                drop;
  logic [EW-1:0]       head;

  assign any_fail = |fail_i;
  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;
  assign push     = any_fail && !clear;
  assign drop     = any_fail && fifo_full && !pop && !clear;
  assign rd_mask  = head[EW-1:TS_WIDTH];
  assign rd_ts    = head[TS_WIDTH-1:0];
  assign status   = state_q;

  log_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ({fail_i, ts}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Free-running timestamp, deliberately untouched by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_count <= '0;
      drop_count <= '0;
      first_mask <= '0;
    end else if (clear) begin
      fail_count <= '0;
      drop_count <= '0;
      first_mask <= '0;
    end else begin
      if (any_fail && !(&fail_count)) fail_count <= fail_count + 1'b1;
      if (drop && !(&drop_count))     drop_count <= drop_count + 1'b1;
      if (any_fail && state_q == ST_OK) first_mask <= fail_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_OK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_OK;
    end else begin
      case (state_q)
        ST_OK:         if (any_fail) state_d = ST_FAILED;
        ST_FAILED:     if (drop) state_d = ST_OVERFLOWED;
        ST_OVERFLOWED: state_d = ST_OVERFLOWED;
        default:       state_d = ST_OK;
      endcase
    end
  end

endmodule

// File: tb/tb_assertion_fail_logger.sv
// Randomised scoreboard bench for assertion_fail_logger against a queue-based reference model.
module tb_assertion_fail_logger;

  localparam int NC    = 4;
  localparam int TW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] fail_i = '0;
  logic          clear = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [NC-1:0] rd_mask;
  logic [TW-1:0] rd_ts;
  logic [CW-1:0] fail_count;
  logic [NC-1:0] first_mask;
  logic [1:0]    status;
  logic [CW-1:0] drop_count;

  assertion_fail_logger #(
    .NUM_CHECKERS (NC),
    .TS_WIDTH     (TW),
    .DEPTH        (DEPTH),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fail_i     (fail_i),
    .clear      (clear),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_mask    (rd_mask),
    .rd_ts      (rd_ts),
    .fail_count (fail_count),
    .first_mask (first_mask),
    .status     (status),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] mask;
    logic [TW-1:0] ts;
  } ent_t;

  int            errors = 0;
  int            checks = 0;
  ent_t          sb[$];
  bit            popped = 0;
  bit            done = 0;
  int            m_fc;
  int            m_dc;
  int            m_status;
  logic [NC-1:0] m_first;
  logic [TW-1:0] m_ts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    popped   = 0;
    m_fc     = 0;
    m_dc     = 0;
    m_status = 0;
    m_first  = '0;
    m_ts     = '0;
  endtask

  // One clock edge of the reference behaviour; the monitor has already removed a popped head.
  task automatic model_edge(input logic [NC-1:0] f, input bit clr);
    bit pop;
    int occ;
    pop    = popped;
    occ    = sb.size() + (pop ? 1 : 0);
    popped = 0;
    if (clr) begin
      sb.delete();
      m_fc     = 0;
      m_dc     = 0;
      m_status = 0;
      m_first  = '0;
    end else if (f != '0) begin
      if (m_fc < CMAX) m_fc++;
      if (m_status == 0) begin
        m_first  = f;
        m_status = 1;
      end
      if (occ < DEPTH || pop) begin
        sb.push_back('{mask: f, ts: m_ts});
      end else begin
        if (m_dc < CMAX) m_dc++;
        m_status = 2;
      end
    end
    m_ts = m_ts + 1'b1;
  endtask

  task automatic step(input logic [NC-1:0] f, input bit rdy, input bit clr);
    fail_i   = f;
    rd_ready = rdy;
    clear    = clr;
    @(posedge clk);
    #1;
    model_edge(f, clr);
  endtask

  function automatic logic [NC-1:0] rand_mask();
    return NC'($urandom_range(1, (1 << NC) - 1));
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_mask"}, 32'(rd_mask), 0);
    chk({tag, "_rd_ts"}, 32'(rd_ts), 0);
    chk({tag, "_fail_count"}, 32'(fail_count), 0);
    chk({tag, "_drop_count"}, 32'(drop_count), 0);
    chk({tag, "_first_mask"}, 32'(first_mask), 0);
    chk({tag, "_status"}, 32'(status), 0);
  endtask

  // Monitor: compares the head against the scoreboard and pops it when the handshake will fire.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !done) begin
        chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
        if (rd_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head: rd_valid high but no entry expected at %0t", $time);
          end else begin
            chk("rd_mask", 32'(rd_mask), 32'(sb[0].mask));
            chk("rd_ts", 32'(rd_ts), 32'(sb[0].ts));
            if (rd_ready) begin
              void'(sb.pop_front());
              popped = 1;
            end
          end
        end
        chk("fail_count", 32'(fail_count), 32'(m_fc));
        chk("drop_count", 32'(drop_count), 32'(m_dc));
        chk("status", 32'(status), 32'(m_status));
        chk("first_mask", 32'(first_mask), 32'(m_first));
      end
    end
  end

  initial begin
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // single event at ts=5 with the consumer ready
    repeat (5) step('0, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);

    // overflow: ten events, nothing drained, then drain in order
    for (int i = 0; i < 10; i++) step(rand_mask(), 1'b0, 1'b0);
    repeat (12) step('0, 1'b1, 1'b0);

    // full FIFO with event and pop on the same edge
    for (int i = 0; i < DEPTH; i++) step(rand_mask(), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(rand_mask(), 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);

    // event coincident with clear
    step(rand_mask(), 1'b0, 1'b0);
    step(rand_mask(), 1'b1, 1'b1);
    repeat (3) step('0, 1'b1, 1'b0);

    // counter saturation
    for (int i = 0; i < 300; i++) step(rand_mask(), 1'($urandom_range(0, 1)), 1'b0);

    // long random run across the timestamp wrap
    for (int i = 0; i < 66000; i++) begin
      logic [NC-1:0] f;
      bit            clr;
      f   = ($urandom_range(0, 7) == 0) ? rand_mask() : '0;
      if (m_ts >= 16'd65530 || m_ts < 16'd4) f = rand_mask();
      clr = ($urandom_range(0, 4999) == 0) && (m_ts > 16'd100) && (m_ts < 16'd65000);
      step(f, 1'($urandom_range(0, 1)), clr);
    end

    // reset in the middle of a drain
    repeat (10) step('0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(rand_mask(), 1'b0, 1'b0);
    fail_i   = '0;
    rd_ready = 1'b1;
    clear    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (4) step('0, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0);

    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
